// File: rtl/quiz_pkg.sv
// Shared types, op codes and display helpers for the arithmetic quiz engine.
package quiz_pkg;

  // Round sequencing: generate operands, show A, B, tens, units, wait for the
  // player, then judge and start the next round.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GEN    = 3'd1,
    ST_SHOW_A = 3'd2,
    ST_SHOW_B = 3'd3,
    ST_SHOW_T = 3'd4,
    ST_SHOW_U = 3'd5,
    ST_ANSWER = 3'd6,
    ST_JUDGE  = 3'd7
  } state_t;

  // Hidden operator codes; they also index switch[2:0].
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;

  // Segment patterns, abcdefg with a in bit 6, 1 = lit.
  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Feedback mask for multiply-by-x modulo x^8+x^6+x^5+x^4+1.
  localparam logic [7:0] LFSR_TAPS = 8'h71;

  // Edge pattern of the skip button on its own.
  localparam logic [3:0] SW_SKIP = 4'b1000;

  // Decimal digit to segment code; anything above 9 is blank.
  function automatic logic [6:0] seg7(input logic [3:0] value);
    logic [6:0] code;
    case (value)
      4'd0:    code = 7'b1111110;
      4'd1:    code = 7'b0110000;
      4'd2:    code = 7'b1101101;
      4'd3:    code = 7'b1111001;
      4'd4:    code = 7'b0110011;
      4'd5:    code = 7'b1011011;
      4'd6:    code = 7'b1011111;
      4'd7:    code = 7'b1110000;
      4'd8:    code = 7'b1111111;
      4'd9:    code = 7'b1111011;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  // Folds a nibble (0..15) into a decimal digit (0..9).
  function automatic logic [3:0] mod10(input logic [3:0] value);
    return (value >= 4'd10) ? (value - 4'd10) : value;
  endfunction

  // Two random bits to an operator; the unused code 3 becomes addition.
  function automatic logic [1:0] op_from_bits(input logic [1:0] bits);
    return (bits == 2'd3) ? OP_ADD : bits;
  endfunction

endpackage

// File: rtl/quiz_lfsr.sv
// 8-bit Galois LFSR for operand generation; steps on every clock.
module quiz_lfsr
  import quiz_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] value
);

  // Shift left and fold the outgoing bit back through the tap mask.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= SEED;
    end else begin
      value <= {value[6:0], 1'b0} ^ (value[7] ? LFSR_TAPS : 8'h00);
    end
  end

endmodule

// File: rtl/quiz_engine.sv
// Arithmetic quiz engine: random operands and hidden operator, paced display
// on one 7-segment digit, player answer on the switches, saturating score.
module quiz_engine
  import quiz_pkg::*;
#(
  parameter int         DIV_BITS     = 19,
  parameter int         SHOW_TICKS   = 3,
  parameter int         ANSWER_TICKS = 15,
  parameter int         MAX_SCORE    = 9,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] switch,
  output logic [6:0] num_led,
  output logic [1:0] digit_sel,
  output logic [6:0] point_led,
  output logic       busy,
  output logic       correct,
  output logic       wrong
);

  localparam logic [7:0]          SHOW_LAST   = 8'(SHOW_TICKS - 1);
  localparam logic [7:0]          ANSWER_LAST = 8'(ANSWER_TICKS - 1);
  localparam logic [3:0]          SCORE_MAX   = 4'(MAX_SCORE);
  localparam logic [DIV_BITS-1:0] PRE_ONE     = DIV_BITS'(1);

  // Pacing
  logic [DIV_BITS-1:0] pre;
  logic                tick;

  // Random source
  logic [7:0] lfsr;
  logic [3:0] p_val;
  logic [3:0] q_val;
  logic [3:0] gen_a;
  logic [3:0] gen_b;

  // Switch input path
  logic [3:0] sw_s1;
  logic [3:0] sw_s2;
  logic [3:0] sw_d;
  logic [3:0] sw_edge;
  logic       single_op;
  logic       op_right;

  // Round state
  state_t     state;
  logic [7:0] tick_cnt;
  logic [3:0] a_val;
  logic [3:0] b_val;
  logic [1:0] op;
  logic       op_load;
  logic [3:0] score;
  logic       enter_gen;

  // Arithmetic
  logic [6:0] sum_ab;
  logic [6:0] diff_ab;
  logic [6:0] prod_ab;
  logic [6:0] result;
  logic [3:0] tens;
  logic [3:0] units;
  logic [2:0] match_vec;

  quiz_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .value (lfsr)
  );

  // Free-running prescaler; its all-ones value is the pacing tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre <= '0;
    end else begin
      pre <= pre + PRE_ONE;
    end
  end

  assign tick = &pre;

  // Two-flop synchroniser plus one delay stage for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_s1 <= 4'b0000;
      sw_s2 <= 4'b0000;
      sw_d  <= 4'b0000;
    end else begin
      sw_s1 <= switch;
      sw_s2 <= sw_s1;
      sw_d  <= sw_s2;
    end
  end

  assign sw_edge = sw_s2 & ~sw_d;

  // Operand candidates from the current LFSR value, larger one first.
  always_comb begin
    p_val = mod10(lfsr[3:0]);
    q_val = mod10(lfsr[7:4]);
    gen_a = (p_val > q_val) ? p_val : q_val;
    gen_b = (p_val > q_val) ? q_val : p_val;
  end

  // All three candidate results; the hidden operator selects the real one.
  always_comb begin
    sum_ab  = {3'b000, a_val} + {3'b000, b_val};
    diff_ab = {3'b000, a_val} - {3'b000, b_val};
    prod_ab = {3'b000, a_val} * {3'b000, b_val};
    case (op)
      OP_ADD:  result = sum_ab;
      OP_SUB:  result = diff_ab;
      OP_MUL:  result = prod_ab;
      default: result = sum_ab;
    endcase
    match_vec = {prod_ab == result, diff_ab == result, sum_ab == result};
  end

  assign tens  = 4'(result / 7'd10);
  assign units = 4'(result % 7'd10);

  // Answer classification: exactly one operator button, and whether it fits.
  always_comb begin
    single_op = $onehot(sw_edge[2:0]) && !sw_edge[3];
    op_right  = |(sw_edge[2:0] & match_vec);
  end

  // A new round starts from IDLE or JUDGE on a tick, or at once on a skip.
  always_comb begin
    enter_gen = 1'b0;
    case (state)
      ST_IDLE:   enter_gen = tick;
      ST_JUDGE:  enter_gen = tick;
      ST_ANSWER: enter_gen = (sw_edge == SW_SKIP);
      default:   enter_gen = 1'b0;
    endcase
  end

  // Round FSM with registered display, score and pulse outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      tick_cnt  <= 8'd0;
      a_val     <= 4'd0;
      b_val     <= 4'd0;
      op        <= OP_ADD;
      op_load   <= 1'b0;
      score     <= 4'd0;
      point_led <= seg7(4'd0);
      num_led   <= SEG_BLANK;
      digit_sel <= 2'd0;
      busy      <= 1'b1;
      correct   <= 1'b0;
      wrong     <= 1'b0;
    end else begin
      correct <= 1'b0;
      wrong   <= 1'b0;
      op_load <= 1'b0;

      // The operator is taken one clock after the operands.
      if (op_load) begin
        op <= op_from_bits(lfsr[1:0]);
      end

      case (state)
        ST_IDLE: begin
          if (tick) begin
            state <= ST_GEN;
          end
        end

        ST_GEN: begin
          if (tick) begin
            state     <= ST_SHOW_A;
            tick_cnt  <= 8'd0;
            num_led   <= seg7(a_val);
            digit_sel <= 2'd0;
          end
        end

        ST_SHOW_A: begin
          if (tick) begin
            if (tick_cnt == SHOW_LAST) begin
              state     <= ST_SHOW_B;
              tick_cnt  <= 8'd0;
              num_led   <= seg7(b_val);
              digit_sel <= 2'd1;
            end else begin
              tick_cnt <= tick_cnt + 8'd1;
            end
          end
        end

        ST_SHOW_B: begin
          if (tick) begin
            if (tick_cnt == SHOW_LAST) begin
              state     <= ST_SHOW_T;
              tick_cnt  <= 8'd0;
              num_led   <= seg7(tens);
              digit_sel <= 2'd2;
            end else begin
              tick_cnt <= tick_cnt + 8'd1;
            end
          end
        end

        ST_SHOW_T: begin
          if (tick) begin
            if (tick_cnt == SHOW_LAST) begin
              state     <= ST_SHOW_U;
              tick_cnt  <= 8'd0;
              num_led   <= seg7(units);
              digit_sel <= 2'd3;
            end else begin
              tick_cnt <= tick_cnt + 8'd1;
            end
          end
        end

        ST_SHOW_U: begin
          if (tick) begin
            if (tick_cnt == SHOW_LAST) begin
              state     <= ST_ANSWER;
              tick_cnt  <= 8'd0;
              num_led   <= SEG_DASH;
              digit_sel <= 2'd3;
              busy      <= 1'b0;
            end else begin
              tick_cnt <= tick_cnt + 8'd1;
            end
          end
        end

        ST_ANSWER: begin
          if (|sw_edge) begin
            // A button edge wins over a coinciding timeout tick.
            if (sw_edge == SW_SKIP) begin
              state <= ST_GEN;
            end else begin
              state    <= ST_JUDGE;
              tick_cnt <= 8'd0;
              busy     <= 1'b1;
              if (single_op && op_right) begin
                correct <= 1'b1;
                if (score < SCORE_MAX) begin
                  score     <= score + 4'd1;
                  point_led <= seg7(score + 4'd1);
                end
              end else begin
                wrong <= 1'b1;
              end
            end
          end else if (tick) begin
            if (tick_cnt == ANSWER_LAST) begin
              state    <= ST_JUDGE;
              tick_cnt <= 8'd0;
              busy     <= 1'b1;
              wrong    <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + 8'd1;
            end
          end
        end

        ST_JUDGE: begin
          if (tick) begin
            state <= ST_GEN;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase

      // Common entry into GEN: latch operands, blank the digit, mark busy.
      if (enter_gen) begin
        a_val     <= gen_a;
        b_val     <= gen_b;
        op_load   <= 1'b1;
        tick_cnt  <= 8'd0;
        num_led   <= SEG_BLANK;
        digit_sel <= 2'd0;
        busy      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_quiz_engine.sv
// Bench for quiz_engine: randomized rounds checked against a round-level
// reference model; answer pulses go through an expected-response queue.
module tb_quiz_engine;

  localparam int         TICK = 4;   // 2^DIV_BITS
  localparam int         SHOW = 1;
  localparam int         ANS  = 4;
  localparam logic [7:0] SEED = 8'h58;  // first round gives A = B = 2, op = add

  localparam logic [1:0] K_CORRECT = 2'b10;
  localparam logic [1:0] K_WRONG   = 2'b01;

  localparam int ACT_PRESS   = 0;
  localparam int ACT_BAD     = 1;
  localparam int ACT_DOUBLE  = 2;
  localparam int ACT_TIMEOUT = 3;
  localparam int ACT_SKIP    = 4;

  logic       clk;
  logic       reset;
  logic [3:0] switch;
  logic [6:0] num_led;
  logic [1:0] digit_sel;
  logic [6:0] point_led;
  logic       busy;
  logic       correct;
  logic       wrong;

  int total = 0;
  int bad   = 0;
  int e_cnt;
  int score_m;
  int g;

  // {kind[1:0], point_led[6:0], cycle[15:0]}
  logic [24:0] exp_q[$];

  quiz_engine #(
    .DIV_BITS     (2),
    .SHOW_TICKS   (SHOW),
    .ANSWER_TICKS (ANS),
    .MAX_SCORE    (9),
    .LFSR_SEED    (SEED)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .switch    (switch),
    .num_led   (num_led),
    .digit_sel (digit_sel),
    .point_led (point_led),
    .busy      (busy),
    .correct   (correct),
    .wrong     (wrong)
  );

  // Clock and a count of clock edges since reset release.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) e_cnt <= 0;
    else       e_cnt <= e_cnt + 1;
  end

  // ---------------- reference helpers ----------------
  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  // Seed multiplied by x^n modulo x^8+x^6+x^5+x^4+1.
  function automatic logic [7:0] lfsr_at(input int n);
    logic [8:0] s;
    s = {1'b0, SEED};
    for (int i = 0; i < n; i++) begin
      s = s << 1;
      if (s[8]) s = s ^ 9'h171;
    end
    return s[7:0];
  endfunction

  function automatic int next_tick(input int k);
    return (k / TICK + 1) * TICK;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, e_cnt);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_num_led"},   32'(num_led),   32'd0);
    check({tag, "_digit_sel"}, 32'(digit_sel), 32'd0);
    check({tag, "_point_led"}, 32'(point_led), 32'(7'b1111110));
    check({tag, "_busy"},      32'(busy),      32'd1);
    check({tag, "_correct"},   32'(correct),   32'd0);
    check({tag, "_wrong"},     32'(wrong),     32'd0);
  endtask

  task automatic push_exp(input logic [1:0] kind, input int cycle);
    exp_q.push_back({kind, seg_of(score_m), 16'(cycle)});
  endtask

  // Monitor: every pulse must match the head of the expected queue.
  always @(negedge clk) begin : monitor
    logic [24:0] ent;
    if (!reset && (correct || wrong)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: correct=%0b wrong=%0b at cycle %0d, required none",
                 correct, wrong, e_cnt);
      end else begin
        ent = exp_q.pop_front();
        check("pulse_kind",      32'({correct, wrong}), 32'(ent[24:23]));
        check("pulse_point_led", 32'(point_led),        32'(ent[22:16]));
        check("pulse_cycle",     32'(e_cnt),            32'(ent[15:0]));
      end
    end
  end

  // ---------------- driver ----------------
  // Returns 1 time unit after clock edge k.
  task automatic goto(input int k);
    while (e_cnt < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One round whose GEN starts at edge g; returns the edge of the next GEN.
  task automatic play_round(input int g_in, input int act, input int k_in, output int g_next);
    logic [7:0] lg;
    logic [7:0] lo;
    logic [2:0] ok;
    logic [3:0] sw_val;
    int p, q, ea, eb, eop, er, t1, a, m, j, k, act_eff;
    lg  = lfsr_at(g_in - 1);
    lo  = lfsr_at(g_in);
    p   = int'(lg[3:0]) % 10;
    q   = int'(lg[7:4]) % 10;
    ea  = (p > q) ? p : q;
    eb  = (p > q) ? q : p;
    eop = (lo[1:0] == 2'd3) ? 0 : int'(lo[1:0]);
    er  = (eop == 0) ? ea + eb : (eop == 1) ? ea - eb : ea * eb;
    ok[0] = (ea + eb == er);
    ok[1] = (ea - eb == er);
    ok[2] = (ea * eb == er);

    t1 = next_tick(g_in);
    a  = t1 + 4 * SHOW * TICK;

    goto(t1 + 2);
    check("show_a_sel",  32'(digit_sel), 32'd0);
    check("show_a_seg",  32'(num_led),   32'(seg_of(ea)));
    check("show_busy",   32'(busy),      32'd1);
    goto(t1 + SHOW * TICK + 2);
    check("show_b_sel",  32'(digit_sel), 32'd1);
    check("show_b_seg",  32'(num_led),   32'(seg_of(eb)));
    goto(t1 + 2 * SHOW * TICK + 2);
    check("show_t_sel",  32'(digit_sel), 32'd2);
    check("show_t_seg",  32'(num_led),   32'(seg_of(er / 10)));
    goto(t1 + 3 * SHOW * TICK + 2);
    check("show_u_sel",  32'(digit_sel), 32'd3);
    check("show_u_seg",  32'(num_led),   32'(seg_of(er % 10)));
    goto(a + 1);
    check("answer_busy", 32'(busy),      32'd0);
    check("answer_dash", 32'(num_led),   32'(7'b0000001));
    check("answer_sel",  32'(digit_sel), 32'd3);

    m = a + 1 + int'($urandom_range(0, 11));
    j = m + 3;
    act_eff = act;
    if (act == ACT_BAD && ok == 3'b111) act_eff = ACT_DOUBLE;

    if (act_eff == ACT_TIMEOUT) begin
      push_exp(K_WRONG, a + ANS * TICK);
      g_next = next_tick(a + ANS * TICK);
    end else begin
      k = k_in;
      if (act_eff == ACT_SKIP) begin
        sw_val = 4'b1000;
      end else if (act_eff == ACT_DOUBLE) begin
        sw_val = 4'b0101;
      end else begin
        if (k < 0) begin
          do k = int'($urandom_range(0, 2)); while ((act_eff == ACT_BAD) ? ok[k] : !ok[k]);
        end
        sw_val = 4'(1 << k);
      end
      goto(m);
      switch = sw_val;
      if (act_eff == ACT_DOUBLE) begin
        push_exp(K_WRONG, j);
      end else if (act_eff != ACT_SKIP) begin
        if (ok[k]) begin
          if (score_m < 9) score_m++;
          push_exp(K_CORRECT, j);
        end else begin
          push_exp(K_WRONG, j);
        end
      end
      goto(m + 4);
      switch = 4'b0000;
      g_next = (act_eff == ACT_SKIP) ? j : next_tick(j);
    end
  endtask

  // Reset in the middle of SHOW_B of the round starting at g_in.
  task automatic reset_in_show_b(input int g_in);
    int t1;
    t1 = next_tick(g_in);
    goto(t1 + SHOW * TICK + 2);
    check("pre_reset_sel", 32'(digit_sel), 32'd1);
    reset = 1'b1;
    #1;
    check_reset("mid_reset");
    @(negedge clk);
    reset   = 1'b0;
    score_m = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset   = 1'b1;
    switch  = 4'b0000;
    score_m = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("in_reset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset("released");

    g = 4;
    play_round(g, ACT_PRESS, 0, g);    // A=B=2: add is right
    play_round(g, ACT_BAD, -1, g);
    play_round(g, ACT_DOUBLE, -1, g);
    play_round(g, ACT_TIMEOUT, -1, g);
    play_round(g, ACT_SKIP, -1, g);
    for (int r = 0; r < 10; r++) begin
      play_round(g, ACT_PRESS, -1, g);
    end
    for (int r = 0; r < 6; r++) begin
      play_round(g, int'($urandom_range(0, 4)), int'($urandom_range(0, 2)), g);
    end

    reset_in_show_b(g);
    g = 4;
    play_round(g, ACT_PRESS, 2, g);    // same first round: mul is also right
    goto(g + 2);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
